arp_eth_rx_filter: RTL and testbench
====================================

Name: arp_eth_rx_filter

Overview:
- Parametrised ARP receive parser and filter; the next generation of the ARP Ethernet receiver.
- Accepts an Ethernet header plus an AXI-stream payload at any byte-multiple DATA_WIDTH and extracts all ARP fields, including THA and TPA.
- Classifies each frame (ARP, request/reply, gratuitous, addressed to us) with width-independent byte matching.
- Optionally drops frames not addressed to the local host. Sits between the Ethernet RX demux and the ARP cache/responder.

Parameters:
DATA_WIDTH, 8, payload width in bits; 8..512, multiple of 8
KEEP_ENABLE, (DATA_WIDTH>8), use tkeep; when 0, tkeep is treated as all ones
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
FILTER_ENABLE, 1, when 1, drop invalid frames and frames whose TPA is not local_ip

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_eth_hdr_valid / s_eth_hdr_ready  in/out  1  Ethernet header handshake
s_eth_dest_mac, s_eth_src_mac  in  48  Ethernet header MACs
s_eth_type  in  16  Ethertype
s_eth_payload_axis_tdata  in  DATA_WIDTH  payload data, byte 0 in lane 0
s_eth_payload_axis_tkeep  in  KEEP_WIDTH  byte enables
s_eth_payload_axis_tvalid / tready / tlast / tuser  in/out/in/in  1  payload handshake; tuser=1 on tlast marks a bad frame
m_frame_valid / m_frame_ready  out/in  1  output frame handshake
m_eth_dest_mac, m_eth_src_mac  out  48  latched Ethernet MACs
m_arp_oper  out  16  ARP operation
m_arp_sha, m_arp_tha  out  48  sender / target hardware address
m_arp_spa, m_arp_tpa  out  32  sender / target protocol address
m_is_request, m_is_reply  out  1  oper==1 / oper==2
m_is_gratuitous  out  1  spa==tpa
m_tpa_match  out  1  tpa==local_ip
m_tha_match  out  1  tha==local_mac, or tha==0 when oper==1
local_mac  in  48  configuration
local_ip  in  32  configuration
busy  out  1  payload header being parsed
drop_frame  out  1  one-cycle pulse: frame filtered
error_header_early_termination  out  1  one-cycle pulse
error_invalid_header  out  1  one-cycle pulse
error_bad_frame  out  1  one-cycle pulse

Behaviour:
- Reset values: all ready, valid, pulse and flag outputs 0; field outputs 0; state HDR; byte pointer 0.
- HDR state:
  - s_eth_hdr_ready = !m_frame_valid.
  - On hdr handshake: latch MACs; record eth_ok = (s_eth_type==16'h0806); go to PAYLOAD with ptr=0.
- PAYLOAD state:
  - tready=1 every cycle, registered.
  - On each accepted beat, for each lane i with tkeep[i] set, byte offset = ptr*KEEP_WIDTH+i.
  - Bytes at offsets 0..27 load htype, ptype, hlen, plen, oper, sha, spa, tha, tpa in big-endian order.
  - ptr increments per beat and saturates at ceil(28/KEEP_WIDTH).
  - Bytes beyond offset 27 (padding/FCS) are consumed and ignored.
  - busy=1 until byte 27 has been captured.
- Final beat (tlast):
  - Evaluated in the accepting cycle using next-state field values.
  - Priority 1: byte 27 not yet received → error_header_early_termination.
  - Priority 2: tuser=1 → error_bad_frame.
  - Priority 3: !eth_ok, htype!=1, ptype!=0x0800, hlen!=6 or plen!=4 → error_invalid_header; with FILTER_ENABLE=0 the frame is still emitted.
  - Priority 4: FILTER_ENABLE=1 and tpa!=local_ip → drop_frame.
  - Otherwise m_frame_valid=1 on the next cycle; latency from the tlast beat is 1 cycle.
  - Return to HDR in all cases.
- Outputs: classification flags are registered alongside the fields and valid together with m_frame_valid. Fields are stable while m_frame_valid && !m_frame_ready.
- Simultaneous events:
  - m_frame_ready together with a new hdr_valid: the header is accepted the following cycle, since hdr_ready is registered.
  - tlast in the same beat as byte 27 is a complete header.
- Reset mid-frame: return to HDR, drop the partial frame, no error pulse.
- local_mac and local_ip are sampled when the tlast beat is accepted.

Optional Feature:
- Macro: ARP_RX_STATS_EN.
- Defined: adds outputs stat_rx_frames, stat_rx_dropped and stat_rx_errors, each 32-bit, cleared by rst.
  - stat_rx_frames increments per emitted frame.
  - stat_rx_dropped increments per drop_frame.
  - stat_rx_errors increments per any error pulse.
  - Counters wrap at 2^32.
- Undefined: these ports and counters do not exist.

Test Plan:
- DATA_WIDTH=8, request with spa=10.0.0.1, tpa=local_ip=10.0.0.5, tha=0 → m_frame_valid 1 cycle after tlast; m_is_request=1, m_tpa_match=1, m_tha_match=1, m_arp_spa=32'h0A000001.
- DATA_WIDTH=64, 60-byte reply with tkeep=8'h0F on the last beat, tha=local_mac → m_is_reply=1, m_arp_tha=local_mac, no errors.
- FILTER_ENABLE=1, tpa=10.0.0.9 → drop_frame pulse, m_frame_valid stays 0, s_eth_hdr_ready returns 1.
- tlast at byte 20 → error_header_early_termination pulse; tlast with tuser=1 on a full frame → error_bad_frame pulse; neither emits a frame.
- Hold m_frame_ready=0 for 10 cycles, then offer a second header → s_eth_hdr_ready=0 until the first frame is accepted, and fields stay stable.
- Assert rst at payload beat 10, then send a clean gratuitous frame (spa=tpa) → m_is_gratuitous=1, no error pulses. With ARP_RX_STATS_EN: stat_rx_frames=1.

Source files
------------

// File: rtl/arp_eth_rx_filter.sv
// ARP receive parser/filter: captures the 28-byte ARP header from an Ethernet payload
// of any byte-multiple width, classifies it and optionally filters it. Optional counters: ARP_RX_STATS_EN.
module arp_eth_rx_filter #(
    parameter int DATA_WIDTH    = 8,
    parameter bit KEEP_ENABLE   = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter bit FILTER_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic                  m_frame_valid,
    input  logic                  m_frame_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_arp_oper,
    output logic [47:0]           m_arp_sha,
    output logic [31:0]           m_arp_spa,
    output logic [47:0]           m_arp_tha,
    output logic [31:0]           m_arp_tpa,
    output logic                  m_is_request,
    output logic                  m_is_reply,
    output logic                  m_is_gratuitous,
    output logic                  m_tpa_match,
    output logic                  m_tha_match,
    input  logic [47:0]           local_mac,
    input  logic [31:0]           local_ip,
    output logic                  busy,
    output logic                  drop_frame,
    output logic                  error_header_early_termination,
    output logic                  error_invalid_header,
`ifdef ARP_RX_STATS_EN
    output logic                  error_bad_frame,
    output logic [31:0]           stat_rx_frames,
    output logic [31:0]           stat_rx_dropped,
    output logic [31:0]           stat_rx_errors
`else
    output logic                  error_bad_frame
`endif
);

    localparam int HDR_BYTES = 28;
    localparam int PTR_MAX   = (HDR_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int PTR_W     = $clog2(PTR_MAX + 1);

    typedef enum logic {
        ST_HDR,
        ST_PAYLOAD
    } state_t;

    state_t            state_q, state_d;
    logic              hdr_ready_q, hdr_ready_d;
    logic              tready_q, tready_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [7:0]        hdr_q [HDR_BYTES];
    logic [7:0]        hdr_d [HDR_BYTES];
    logic              got_last_q, got_last_d;
    logic              eth_ok_q, eth_ok_d;
    logic [47:0]       eth_dest_q, eth_dest_d;
    logic [47:0]       eth_src_q, eth_src_d;
    logic              frame_valid_q, frame_valid_d;
    logic [47:0]       out_dest_q, out_dest_d;
    logic [47:0]       out_src_q, out_src_d;
    logic [15:0]       out_oper_q, out_oper_d;
    logic [47:0]       out_sha_q, out_sha_d;
    logic [31:0]       out_spa_q, out_spa_d;
    logic [47:0]       out_tha_q, out_tha_d;
    logic [31:0]       out_tpa_q, out_tpa_d;
    logic              is_req_q, is_req_d;
    logic              is_rep_q, is_rep_d;
    logic              is_grat_q, is_grat_d;
    logic              tpa_match_q, tpa_match_d;
    logic              tha_match_q, tha_match_d;
    logic              drop_q, drop_d;
    logic              err_early_q, err_early_d;
    logic              err_inv_q, err_inv_d;
    logic              err_bad_q, err_bad_d;
    logic              emit;

    logic [KEEP_WIDTH-1:0] keep_eff;
    logic                  hdr_fire;
    logic                  beat_fire;
    int                    offset;

    logic [15:0] htype_n, ptype_n, oper_n;
    logic [7:0]  hlen_n, plen_n;
    logic [47:0] sha_n, tha_n;
    logic [31:0] spa_n, tpa_n;
    logic        header_ok;

    assign keep_eff  = KEEP_ENABLE ? s_eth_payload_axis_tkeep : '1;
    assign hdr_fire  = s_eth_hdr_valid && hdr_ready_q;
    assign beat_fire = s_eth_payload_axis_tvalid && tready_q;

    // Byte capture: each enabled lane lands at its absolute payload offset, so the
    // same logic works for every bus width; bytes past the ARP header are discarded.
    always_comb begin
        hdr_d      = hdr_q;
        got_last_d = got_last_q;
        ptr_d      = ptr_q;
        offset     = 0;
        if (state_q == ST_HDR && hdr_fire) begin
            hdr_d      = '{default: '0};
            got_last_d = 1'b0;
            ptr_d      = '0;
        end else if (state_q == ST_PAYLOAD && beat_fire) begin
            for (int i = 0; i < KEEP_WIDTH; i++) begin
                offset = int'(ptr_q) * KEEP_WIDTH + i;
                if (keep_eff[i] && offset < HDR_BYTES) begin
                    hdr_d[offset[4:0]] = s_eth_payload_axis_tdata[8*i +: 8];
                    if (offset == HDR_BYTES - 1) begin
                        got_last_d = 1'b1;
                    end
                end
            end
            if (ptr_q != PTR_W'(PTR_MAX)) begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    assign htype_n   = {hdr_d[0], hdr_d[1]};
    assign ptype_n   = {hdr_d[2], hdr_d[3]};
    assign hlen_n    = hdr_d[4];
    assign plen_n    = hdr_d[5];
    assign oper_n    = {hdr_d[6], hdr_d[7]};
    assign sha_n     = {hdr_d[8], hdr_d[9], hdr_d[10], hdr_d[11], hdr_d[12], hdr_d[13]};
    assign spa_n     = {hdr_d[14], hdr_d[15], hdr_d[16], hdr_d[17]};
    assign tha_n     = {hdr_d[18], hdr_d[19], hdr_d[20], hdr_d[21], hdr_d[22], hdr_d[23]};
    assign tpa_n     = {hdr_d[24], hdr_d[25], hdr_d[26], hdr_d[27]};
    assign header_ok = eth_ok_q && (htype_n == 16'd1) && (ptype_n == 16'h0800) &&
                       (hlen_n == 8'd6) && (plen_n == 8'd4);

    // Control: header handshake, end-of-frame classification and output holding.
    // The tlast verdict uses this cycle's captured bytes so a header that completes
    // on the last beat is judged correctly.
    always_comb begin
        state_d       = state_q;
        tready_d      = tready_q;
        eth_ok_d      = eth_ok_q;
        eth_dest_d    = eth_dest_q;
        eth_src_d     = eth_src_q;
        frame_valid_d = frame_valid_q;
        out_dest_d    = out_dest_q;
        out_src_d     = out_src_q;
        out_oper_d    = out_oper_q;
        out_sha_d     = out_sha_q;
        out_spa_d     = out_spa_q;
        out_tha_d     = out_tha_q;
        out_tpa_d     = out_tpa_q;
        is_req_d      = is_req_q;
        is_rep_d      = is_rep_q;
        is_grat_d     = is_grat_q;
        tpa_match_d   = tpa_match_q;
        tha_match_d   = tha_match_q;
        drop_d        = 1'b0;
        err_early_d   = 1'b0;
        err_inv_d     = 1'b0;
        err_bad_d     = 1'b0;
        emit          = 1'b0;

        if (frame_valid_q && m_frame_ready) begin
            frame_valid_d = 1'b0;
        end

        case (state_q)
            ST_HDR: begin
                if (hdr_fire) begin
                    eth_dest_d = s_eth_dest_mac;
                    eth_src_d  = s_eth_src_mac;
                    eth_ok_d   = (s_eth_type == 16'h0806);
                    tready_d   = 1'b1;
                    state_d    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (beat_fire && s_eth_payload_axis_tlast) begin
                    tready_d = 1'b0;
                    state_d  = ST_HDR;
                    if (!got_last_d) begin
                        err_early_d = 1'b1;
                    end else if (s_eth_payload_axis_tuser) begin
                        err_bad_d = 1'b1;
                    end else if (!header_ok) begin
                        err_inv_d = 1'b1;
                        emit      = !FILTER_ENABLE;
                    end else if (FILTER_ENABLE && (tpa_n != local_ip)) begin
                        drop_d = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase

        if (emit) begin
            frame_valid_d = 1'b1;
            out_dest_d    = eth_dest_q;
            out_src_d     = eth_src_q;
            out_oper_d    = oper_n;
            out_sha_d     = sha_n;
            out_spa_d     = spa_n;
            out_tha_d     = tha_n;
            out_tpa_d     = tpa_n;
            is_req_d      = (oper_n == 16'd1);
            is_rep_d      = (oper_n == 16'd2);
            is_grat_d     = (spa_n == tpa_n);
            tpa_match_d   = (tpa_n == local_ip);
            tha_match_d   = (tha_n == local_mac) || ((oper_n == 16'd1) && (tha_n == 48'd0));
        end

        hdr_ready_d = (state_d == ST_HDR) && !frame_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_HDR;
            hdr_ready_q   <= 1'b0;
            tready_q      <= 1'b0;
            ptr_q         <= '0;
            hdr_q         <= '{default: '0};
            got_last_q    <= 1'b0;
            eth_ok_q      <= 1'b0;
            eth_dest_q    <= '0;
            eth_src_q     <= '0;
            frame_valid_q <= 1'b0;
            out_dest_q    <= '0;
            out_src_q     <= '0;
            out_oper_q    <= '0;
            out_sha_q     <= '0;
            out_spa_q     <= '0;
            out_tha_q     <= '0;
            out_tpa_q     <= '0;
            is_req_q      <= 1'b0;
            is_rep_q      <= 1'b0;
            is_grat_q     <= 1'b0;
            tpa_match_q   <= 1'b0;
            tha_match_q   <= 1'b0;
            drop_q        <= 1'b0;
            err_early_q   <= 1'b0;
            err_inv_q     <= 1'b0;
            err_bad_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_ready_q   <= hdr_ready_d;
            tready_q      <= tready_d;
            ptr_q         <= ptr_d;
            hdr_q         <= hdr_d;
            got_last_q    <= got_last_d;
            eth_ok_q      <= eth_ok_d;
            eth_dest_q    <= eth_dest_d;
            eth_src_q     <= eth_src_d;
            frame_valid_q <= frame_valid_d;
            out_dest_q    <= out_dest_d;
            out_src_q     <= out_src_d;
            out_oper_q    <= out_oper_d;
            out_sha_q     <= out_sha_d;
            out_spa_q     <= out_spa_d;
            out_tha_q     <= out_tha_d;
            out_tpa_q     <= out_tpa_d;
            is_req_q      <= is_req_d;
            is_rep_q      <= is_rep_d;
            is_grat_q     <= is_grat_d;
            tpa_match_q   <= tpa_match_d;
            tha_match_q   <= tha_match_d;
            drop_q        <= drop_d;
            err_early_q   <= err_early_d;
            err_inv_q     <= err_inv_d;
            err_bad_q     <= err_bad_d;
        end
    end

`ifdef ARP_RX_STATS_EN
    logic [31:0] stat_frames_q, stat_frames_d;
    logic [31:0] stat_dropped_q, stat_dropped_d;
    logic [31:0] stat_errors_q, stat_errors_d;

    always_comb begin
        stat_frames_d  = stat_frames_q + (emit ? 32'd1 : 32'd0);
        stat_dropped_d = stat_dropped_q + (drop_d ? 32'd1 : 32'd0);
        stat_errors_d  = stat_errors_q + ((err_early_d || err_bad_d || err_inv_d) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames_q  <= '0;
            stat_dropped_q <= '0;
            stat_errors_q  <= '0;
        end else begin
            stat_frames_q  <= stat_frames_d;
            stat_dropped_q <= stat_dropped_d;
            stat_errors_q  <= stat_errors_d;
        end
    end

    assign stat_rx_frames  = stat_frames_q;
    assign stat_rx_dropped = stat_dropped_q;
    assign stat_rx_errors  = stat_errors_q;
`endif

    assign s_eth_hdr_ready                = hdr_ready_q;
    assign s_eth_payload_axis_tready      = tready_q;
    assign m_frame_valid                  = frame_valid_q;
    assign m_eth_dest_mac                 = out_dest_q;
    assign m_eth_src_mac                  = out_src_q;
    assign m_arp_oper                     = out_oper_q;
    assign m_arp_sha                      = out_sha_q;
    assign m_arp_spa                      = out_spa_q;
    assign m_arp_tha                      = out_tha_q;
    assign m_arp_tpa                      = out_tpa_q;
    assign m_is_request                   = is_req_q;
    assign m_is_reply                     = is_rep_q;
    assign m_is_gratuitous                = is_grat_q;
    assign m_tpa_match                    = tpa_match_q;
    assign m_tha_match                    = tha_match_q;
    assign busy                           = (state_q == ST_PAYLOAD) && !got_last_q;
    assign drop_frame                     = drop_q;
    assign error_header_early_termination = err_early_q;
    assign error_invalid_header           = err_inv_q;
    assign error_bad_frame                = err_bad_q;

endmodule

// File: tb/tb_arp_eth_rx_filter.sv
// Directed, table-driven bench for arp_eth_rx_filter: an 8-bit instance for the
// vector table and corner sequences, plus a 64-bit instance for a wide-bus reply.
module tb_arp_eth_rx_filter;

    localparam logic [47:0] LMAC = 48'h02_00_00_00_00_05;
    localparam logic [31:0] LIP  = 32'h0A00_0005;
    localparam logic [47:0] SHA  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] DMAC = 48'hFF_FF_FF_FF_FF_FF;

    typedef struct {
        logic [15:0] eth_type;
        logic [15:0] htype;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
        int          len;
        bit          tuser;
        bit          exp_valid;
        bit          exp_drop;
        bit          exp_early;
        bit          exp_bad;
        bit          exp_inv;
        bit          exp_req;
        bit          exp_rep;
        bit          exp_grat;
        bit          exp_tpam;
        bit          exp_tham;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] local_mac = LMAC;
    logic [31:0] local_ip = LIP;
    logic [47:0] dest_mac = DMAC;
    logic [47:0] src_mac = SHA;
    logic [15:0] eth_type = 16'h0806;

    logic        hdr_valid = 1'b0, hdr_ready;
    logic [7:0]  tdata = '0;
    logic [0:0]  tkeep = 1'b1;
    logic        tvalid = 1'b0, tready, tlast = 1'b0, tuser = 1'b0;
    logic        m_valid, m_ready = 1'b0;
    logic [47:0] o_dest, o_src, o_sha, o_tha;
    logic [15:0] o_oper;
    logic [31:0] o_spa, o_tpa;
    logic        o_req, o_rep, o_grat, o_tpam, o_tham;
    logic        busy, drop_p, early_p, inv_p, bad_p;

    logic        hdr_valid64 = 1'b0, hdr_ready64;
    logic [63:0] tdata64 = '0;
    logic [7:0]  tkeep64 = '0;
    logic        tvalid64 = 1'b0, tready64, tlast64 = 1'b0, tuser64 = 1'b0;
    logic        m_valid64, m_ready64 = 1'b0;
    logic [47:0] o64_dest, o64_src, o64_sha, o64_tha;
    logic [15:0] o64_oper;
    logic [31:0] o64_spa, o64_tpa;
    logic        o64_req, o64_rep, o64_grat, o64_tpam, o64_tham;
    logic        busy64, drop64, early64, inv64, bad64;

`ifdef ARP_RX_STATS_EN
    logic [31:0] stat_frames, stat_dropped, stat_errors;
    logic [31:0] stat64_frames, stat64_dropped, stat64_errors;
`endif

    int checks = 0;
    int failures = 0;
    int cnt_drop = 0, cnt_early = 0, cnt_inv = 0, cnt_bad = 0, cnt64_evt = 0;
    int snap_drop, snap_early, snap_inv, snap_bad, snap64;
    logic [7:0] fb [64];
    vec_t vecs [14];

    always #5 clk = ~clk;

    arp_eth_rx_filter dut (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(hdr_valid), .s_eth_hdr_ready(hdr_ready),
        .s_eth_dest_mac(dest_mac), .s_eth_src_mac(src_mac), .s_eth_type(eth_type),
        .s_eth_payload_axis_tdata(tdata), .s_eth_payload_axis_tkeep(tkeep),
        .s_eth_payload_axis_tvalid(tvalid), .s_eth_payload_axis_tready(tready),
        .s_eth_payload_axis_tlast(tlast), .s_eth_payload_axis_tuser(tuser),
        .m_frame_valid(m_valid), .m_frame_ready(m_ready),
        .m_eth_dest_mac(o_dest), .m_eth_src_mac(o_src), .m_arp_oper(o_oper),
        .m_arp_sha(o_sha), .m_arp_spa(o_spa), .m_arp_tha(o_tha), .m_arp_tpa(o_tpa),
        .m_is_request(o_req), .m_is_reply(o_rep), .m_is_gratuitous(o_grat),
        .m_tpa_match(o_tpam), .m_tha_match(o_tham),
        .local_mac(local_mac), .local_ip(local_ip), .busy(busy),
        .drop_frame(drop_p), .error_header_early_termination(early_p),
        .error_invalid_header(inv_p),
`ifdef ARP_RX_STATS_EN
        .error_bad_frame(bad_p),
        .stat_rx_frames(stat_frames), .stat_rx_dropped(stat_dropped), .stat_rx_errors(stat_errors)
`else
        .error_bad_frame(bad_p)
`endif
    );

    arp_eth_rx_filter #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(hdr_valid64), .s_eth_hdr_ready(hdr_ready64),
        .s_eth_dest_mac(dest_mac), .s_eth_src_mac(src_mac), .s_eth_type(eth_type),
        .s_eth_payload_axis_tdata(tdata64), .s_eth_payload_axis_tkeep(tkeep64),
        .s_eth_payload_axis_tvalid(tvalid64), .s_eth_payload_axis_tready(tready64),
        .s_eth_payload_axis_tlast(tlast64), .s_eth_payload_axis_tuser(tuser64),
        .m_frame_valid(m_valid64), .m_frame_ready(m_ready64),
        .m_eth_dest_mac(o64_dest), .m_eth_src_mac(o64_src), .m_arp_oper(o64_oper),
        .m_arp_sha(o64_sha), .m_arp_spa(o64_spa), .m_arp_tha(o64_tha), .m_arp_tpa(o64_tpa),
        .m_is_request(o64_req), .m_is_reply(o64_rep), .m_is_gratuitous(o64_grat),
        .m_tpa_match(o64_tpam), .m_tha_match(o64_tham),
        .local_mac(local_mac), .local_ip(local_ip), .busy(busy64),
        .drop_frame(drop64), .error_header_early_termination(early64),
        .error_invalid_header(inv64),
`ifdef ARP_RX_STATS_EN
        .error_bad_frame(bad64),
        .stat_rx_frames(stat64_frames), .stat_rx_dropped(stat64_dropped), .stat_rx_errors(stat64_errors)
`else
        .error_bad_frame(bad64)
`endif
    );

    // Pulses are counted here so a one-cycle pulse is never missed between checks.
    always @(negedge clk) begin
        if (drop_p)  cnt_drop++;
        if (early_p) cnt_early++;
        if (inv_p)   cnt_inv++;
        if (bad_p)   cnt_bad++;
        if (drop64 || early64 || inv64 || bad64) cnt64_evt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_frame(input vec_t v);
        for (int k = 0; k < 64; k++) fb[k] = 8'hAA;
        fb[0] = v.htype[15:8]; fb[1] = v.htype[7:0];
        fb[2] = 8'h08; fb[3] = 8'h00; fb[4] = 8'd6; fb[5] = 8'd4;
        fb[6] = v.oper[15:8]; fb[7] = v.oper[7:0];
        for (int k = 0; k < 6; k++) begin
            fb[8 + k]  = v.sha[47 - 8*k -: 8];
            fb[18 + k] = v.tha[47 - 8*k -: 8];
        end
        for (int k = 0; k < 4; k++) begin
            fb[14 + k] = v.spa[31 - 8*k -: 8];
            fb[24 + k] = v.tpa[31 - 8*k -: 8];
        end
    endtask

    // Called at a negedge; returns at the negedge right after the tlast beat
    // (or right after a reset pulse when rst_at selects a beat).
    task automatic applyStimulus(input vec_t v, input int rst_at);
        int n;
        snap_drop = cnt_drop; snap_early = cnt_early; snap_inv = cnt_inv; snap_bad = cnt_bad;
        build_frame(v);
        eth_type  = v.eth_type;
        hdr_valid = 1'b1;
        n = 0;
        while (!hdr_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("hdr_ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        hdr_valid = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            tdata  = fb[i];
            tvalid = 1'b1;
            tlast  = (i == v.len - 1);
            tuser  = v.tuser && (i == v.len - 1);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
                return;
            end
            n = 0;
            while (!tready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) check("tready_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v);
        check("valid_latency", m_valid, v.exp_valid);
        @(negedge clk);
        check("drop_pulse",  cnt_drop - snap_drop,   v.exp_drop);
        check("early_pulse", cnt_early - snap_early, v.exp_early);
        check("bad_pulse",   cnt_bad - snap_bad,     v.exp_bad);
        check("inv_pulse",   cnt_inv - snap_inv,     v.exp_inv);
        check("valid_hold",  m_valid, v.exp_valid);
        check("busy_idle",   busy, 1'b0);
        if (v.exp_valid) begin
            check("hdr_ready_while_valid", hdr_ready, 1'b0);
            check("is_request", o_req,  v.exp_req);
            check("is_reply",   o_rep,  v.exp_rep);
            check("is_grat",    o_grat, v.exp_grat);
            check("tpa_match",  o_tpam, v.exp_tpam);
            check("tha_match",  o_tham, v.exp_tham);
            check("oper", o_oper, v.oper);
            check("sha",  o_sha,  v.sha);
            check("spa",  o_spa,  v.spa);
            check("tha",  o_tha,  v.tha);
            check("tpa",  o_tpa,  v.tpa);
            check("dest_mac", o_dest, DMAC);
            check("src_mac",  o_src,  SHA);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
            check("valid_cleared", m_valid, 1'b0);
        end
        check("hdr_ready_after", hdr_ready, 1'b1);
    endtask

    initial begin
        int n;
        // order: eth_type, htype, oper, sha, spa, tha, tpa, len, tuser,
        //        valid, drop, early, bad, inv, req, rep, grat, tpam, tham
        vecs[0]  = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000001, 48'd0, LIP, 42, 0, 1,0,0,0,0, 1,0,0,1,1};
        vecs[1]  = '{16'h0806, 16'd1, 16'd2, SHA, 32'h0A000007, LMAC,  LIP, 42, 0, 1,0,0,0,0, 0,1,0,1,1};
        vecs[2]  = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000001, 48'd0, 32'h0A000009, 42, 0, 0,1,0,0,0, 0,0,0,0,0};
        vecs[3]  = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000001, 48'd0, LIP, 21, 0, 0,0,1,0,0, 0,0,0,0,0};
        vecs[4]  = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000001, 48'd0, LIP, 42, 1, 0,0,0,1,0, 0,0,0,0,0};
        vecs[5]  = '{16'h0800, 16'd1, 16'd1, SHA, 32'h0A000001, 48'd0, LIP, 42, 0, 0,0,0,0,1, 0,0,0,0,0};
        vecs[6]  = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000001, 48'h112233445566, LIP, 42, 0, 1,0,0,0,0, 1,0,0,1,0};
        vecs[7]  = '{16'h0806, 16'd1, 16'd2, SHA, 32'h0A000001, 48'd0, LIP, 42, 0, 1,0,0,0,0, 0,1,0,1,0};
        vecs[8]  = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000002, 48'd0, LIP, 28, 0, 1,0,0,0,0, 1,0,0,1,1};
        vecs[9]  = '{16'h0806, 16'd1, 16'd3, SHA, 32'h0A000003, LMAC,  LIP, 42, 0, 1,0,0,0,0, 0,0,0,1,1};
        vecs[10] = '{16'h0806, 16'd6, 16'd1, SHA, 32'h0A000001, 48'd0, LIP, 42, 0, 0,0,0,0,1, 0,0,0,0,0};
        vecs[11] = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000001, 48'd0, LIP, 27, 0, 0,0,1,0,0, 0,0,0,0,0};
        vecs[12] = '{16'h0806, 16'd1, 16'd1, SHA, 32'h0A000001, 48'd0, LIP, 21, 1, 0,0,1,0,0, 0,0,0,0,0};
        vecs[13] = '{16'h0806, 16'd1, 16'd1, SHA, LIP,          48'd0, LIP, 42, 0, 1,0,0,0,0, 1,0,1,1,1};

        repeat (3) @(negedge clk);
        check("rst_hdr_ready", hdr_ready, 1'b0);
        check("rst_tready",    tready,    1'b0);
        check("rst_valid",     m_valid,   1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_oper",      o_oper,    16'd0);
        check("rst_flags",     {o_req, o_rep, o_grat, o_tpam, o_tham}, 5'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_hdr_ready", hdr_ready, 1'b1);

        for (int t = 0; t < 13; t++) begin
            $display("[TB] vector %0d", t);
            applyStimulus(vecs[t], -1);
            checkOutput(vecs[t]);
        end

        $display("[TB] backpressure sequence");
        applyStimulus(vecs[0], -1);
        check("bp_valid", m_valid, 1'b1);
        repeat (10) @(negedge clk);
        check("bp_valid_held", m_valid, 1'b1);
        check("bp_spa_stable", o_spa, 32'h0A000001);
        fork
            applyStimulus(vecs[1], -1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("bp_hdr_ready_low", hdr_ready, 1'b0);
                    check("bp_tha_stable", o_tha, 48'd0);
                end
                m_ready = 1'b1;
                @(negedge clk);
                m_ready = 1'b0;
                check("bp_first_consumed", m_valid, 1'b0);
            end
        join
        checkOutput(vecs[1]);

        $display("[TB] reset mid-frame then gratuitous frame");
        applyStimulus(vecs[13], 10);
        @(negedge clk);
        check("midrst_valid", m_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_no_errors", (cnt_early - snap_early) + (cnt_bad - snap_bad) + (cnt_inv - snap_inv) + (cnt_drop - snap_drop), 0);
        check("midrst_hdr_ready", hdr_ready, 1'b1);
        applyStimulus(vecs[13], -1);
`ifdef ARP_RX_STATS_EN
        check("stat_rx_frames", stat_frames, 32'd1);
        check("stat_rx_errors", stat_errors, 32'd0);
`endif
        checkOutput(vecs[13]);

        $display("[TB] 64-bit reply, 60 bytes");
        build_frame(vecs[1]);
        eth_type = 16'h0806;
        snap64 = cnt64_evt;
        hdr_valid64 = 1'b1;
        n = 0;
        while (!hdr_ready64 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check("hdr_ready64_timeout", 64'd0, 64'd1);
        @(negedge clk);
        hdr_valid64 = 1'b0;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 8; i++) tdata64[8*i +: 8] = fb[8*j + i];
            tkeep64  = (j == 7) ? 8'h0F : 8'hFF;
            tvalid64 = 1'b1;
            tlast64  = (j == 7);
            n = 0;
            while (!tready64 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) check("tready64_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        tvalid64 = 1'b0; tlast64 = 1'b0;
        check("w64_valid_latency", m_valid64, 1'b1);
        @(negedge clk);
        check("w64_no_events", cnt64_evt - snap64, 0);
        check("w64_is_reply", o64_rep, 1'b1);
        check("w64_is_request", o64_req, 1'b0);
        check("w64_tha", o64_tha, LMAC);
        check("w64_spa", o64_spa, 32'h0A000007);
        check("w64_tha_match", o64_tham, 1'b1);
        m_ready64 = 1'b1;
        @(negedge clk);
        m_ready64 = 1'b0;
        check("w64_valid_cleared", m_valid64, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
